// File: rtl/gps_pkg.sv
// Shared GPS-side receive types: UART framing constants and receiver FSM states.
package gps_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/gps_uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops reset to RESET_VAL.
// Latency: 2 cycles; no backpressure.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/gps_uart_byte_rx.sv
// 8N1 UART receiver: byte out on valid/ready, plus framing-error and overrun pulses.
// Latency: byte valid on the edge after the mid-stop-bit sample; a full holding register drops new bytes (overrun).
module gps_uart_byte_rx
    import gps_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      fe_q, fe_d;
    logic                      ov_q, ov_d;
    logic                      brk_q, brk_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (rx),
        .q_out (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        brk_d   = brk_q;

        if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // After a low stop bit the line must be seen high before a new start counts.
                if (brk_q) begin
                    if (rx_s) begin
                        brk_d = 1'b0;
                    end
                end else if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        // A byte being consumed this cycle frees the register for the new one.
                        if (!valid_q || byte_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d  = 1'b1;
                        brk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            brk_q   <= brk_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gps_uart_byte_rx.sv
// Directed and randomized bench for gps_uart_byte_rx at 16 clocks per bit.
module tb_gps_uart_byte_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    gps_uart_byte_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log of DUT outputs, sampled mid-cycle.
    int         fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, last_rise = 0, vhigh_cnt = 0, stab_err = 0;
    logic       busy_seen = 1'b0;
    logic       prev_valid = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] acc_q[$];

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (busy) busy_seen = 1'b1;
        if (byte_valid) vhigh_cnt++;
        if (byte_valid && !prev_valid) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (prev_valid && !prev_acc && byte_valid && byte_data !== prev_data) stab_err++;
        if (byte_valid && byte_ready) acc_q.push_back(byte_data);
        prev_valid = byte_valid;
        prev_acc   = byte_valid && byte_ready;
        prev_data  = byte_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        step(n);
    endtask

    int fall_cyc = 0;

    // One 8N1 frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
    endtask

    function automatic logic [7:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 8'hxx;
    endfunction

    int         b_rise, b_fe, b_ov, b_vh, fe_exp;
    logic [7:0] rbyte;
    logic       good;
    logic [7:0] exp_q[$];

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        byte_ready = 1'b1;
        step(3);
        check("rst_valid", byte_valid, 0);
        check("rst_data", byte_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step(20);

        // Single byte with consumer ready
        b_rise = rise_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_vh = vhigh_cnt;
        acc_q.delete();
        send_frame(8'hA5, 1'b1);
        step(10);
        check("s1_rises", rise_cnt - b_rise, 1);
        check("s1_latency", last_rise - fall_cyc, 155);
        check("s1_pulse_width", vhigh_cnt - b_vh, 1);
        check("s1_count", acc_q.size(), 1);
        check("s1_data", acc_at(0), 8'hA5);
        check("s1_no_fe", fe_cnt - b_fe, 0);
        check("s1_no_ov", ov_cnt - b_ov, 0);

        // Framing error followed by a held break, then a good byte
        b_rise = rise_cnt; b_fe = fe_cnt;
        acc_q.delete();
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 3 * CPB);
        drive_bit(1'b1, CPB);
        check("s3_fe_pulse", fe_cnt - b_fe, 1);
        check("s3_no_valid", rise_cnt - b_rise, 0);
        send_frame(8'h0D, 1'b1);
        step(10);
        check("s3_count", acc_q.size(), 1);
        check("s3_data", acc_at(0), 8'h0D);
        check("s3_fe_total", fe_cnt - b_fe, 1);

        // Glitch rejection
        b_rise = rise_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
        busy_seen = 1'b0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("s4_busy_seen", busy_seen, 1);
        check("s4_busy_idle", busy, 0);
        check("s4_no_valid", rise_cnt - b_rise, 0);
        check("s4_no_fe", fe_cnt - b_fe, 0);
        check("s4_no_ov", ov_cnt - b_ov, 0);

        // Back-to-back with consumer stalled, then hold and single-cycle accept
        b_ov = ov_cnt;
        acc_q.delete();
        byte_ready = 1'b0;
        send_frame(8'h24, 1'b1);
        send_frame(8'h47, 1'b1);
        step(2);
        check("s2_overrun", ov_cnt - b_ov, 1);
        check("s2_valid", byte_valid, 1);
        check("s2_data", byte_data, 8'h24);
        step(100);
        check("s6_hold_valid", byte_valid, 1);
        check("s6_hold_data", byte_data, 8'h24);
        byte_ready = 1'b1;
        step(1);
        byte_ready = 1'b0;
        check("s6_cleared", byte_valid, 0);
        check("s6_count", acc_q.size(), 1);
        check("s6_data", acc_at(0), 8'h24);

        // Reset during data bit 3 with a byte pending
        rbyte = 8'($urandom_range(1, 255));
        send_frame(rbyte, 1'b1);
        step(4);
        check("s5_pending_data", byte_data, rbyte);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, 3 * CPB + CPB / 2);
        check("s5_busy_mid", busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("s5_rst_valid", byte_valid, 0);
        check("s5_rst_data", byte_data, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_fe", frame_err, 0);
        check("s5_rst_ov", overrun, 0);
        byte_ready = 1'b1;
        acc_q.delete();
        drive_bit(1'b1, CPB);
        send_frame(8'h55, 1'b1);
        step(10);
        check("s5_count", acc_q.size(), 1);
        check("s5_data", acc_at(0), 8'h55);

        // Randomized frames against a queue model
        acc_q.delete();
        exp_q.delete();
        b_fe = fe_cnt; b_ov = ov_cnt;
        fe_exp = 0;
        for (int f = 0; f < 12; f++) begin
            rbyte = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(rbyte, good);
            if (good) begin
                exp_q.push_back(rbyte);
                drive_bit(1'b1, $urandom_range(0, 1) * CPB);
            end else begin
                fe_exp++;
                drive_bit(1'b1, CPB);
            end
        end
        step(10);
        check("rnd_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check("rnd_data", acc_at(i), exp_q[i]);
        check("rnd_fe", fe_cnt - b_fe, fe_exp);
        check("rnd_no_ov", ov_cnt - b_ov, 0);
        check("data_stability", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
